// File: rtl/stdp_pkg.sv
// Shared defaults and arithmetic helpers for the STDP synapse array.
package stdp_pkg;

  localparam int N_SYN_D      = 4;
  localparam int TW_D         = 8;
  localparam int WW_D         = 8;
  localparam int WINDOW_D     = 16;
  localparam int DECAY_STEP_D = 4;
  localparam int LTP_MAX_D    = 16;
  localparam int LTD_MAX_D    = 8;
  localparam int W_INIT_D     = 32;
  localparam int W_MIN_D      = 0;
  localparam int W_MAX_D      = 255;

  // Update magnitude halves every `step` cycles of spike separation.
  function automatic int decay(input int mag, input int e, input int step);
    return mag >> (e / step);
  endfunction

  // Potentiation: the sum is formed wider than the weight, then clamped.
  function automatic int sat_add(input int w, input int d, input int hi);
    return (w + d > hi) ? hi : w + d;
  endfunction

  // Depression: signed difference, so underflow clamps instead of wrapping.
  function automatic int sat_sub(input int w, input int d, input int lo);
    return (w - d < lo) ? lo : w - d;
  endfunction

endpackage

// File: rtl/stdp_timer.sv
// Saturating time-since-last-spike counter with a seen flag.
// e is the elapsed time as seen by pairing logic this cycle: 0 for a spike
// arriving now, otherwise counter+1 saturated.
module stdp_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          spike,
  output logic [TW-1:0] e,
  output logic          seen
);

  localparam logic [TW-1:0] SAT = '1;

  logic [TW-1:0] cnt;
  logic          seen_q;

  // Restart on a spike, otherwise count up and stick at the top.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      seen_q <= 1'b0;
    end else if (spike) begin
      cnt    <= '0;
      seen_q <= 1'b1;
    end else if (cnt != SAT) begin
      cnt    <= cnt + 1'b1;
    end
  end

  // A same-cycle spike counts as seen with zero separation.
  always_comb begin
    e    = spike ? '0 : ((cnt == SAT) ? SAT : cnt + 1'b1);
    seen = seen_q | spike;
  end

endmodule

// File: rtl/stdp_array.sv
// Pair-based STDP over N_SYN synapses feeding one postsynaptic neuron.
// Weights are registered; updates and pulses appear one cycle after spikes.
module stdp_array
  import stdp_pkg::*;
#(
  parameter int N_SYN      = N_SYN_D,
  parameter int TW         = TW_D,
  parameter int WW         = WW_D,
  parameter int WINDOW     = WINDOW_D,
  parameter int DECAY_STEP = DECAY_STEP_D,
  parameter int LTP_MAX    = LTP_MAX_D,
  parameter int LTD_MAX    = LTD_MAX_D,
  parameter int W_INIT     = W_INIT_D,
  parameter int W_MIN      = W_MIN_D,
  parameter int W_MAX      = W_MAX_D,
  localparam int IW        = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_SYN-1:0]    pre_spike,
  input  logic                post_spike,
  input  logic                learn_en,
  input  logic                wr_en,
  input  logic [IW-1:0]       wr_idx,
  input  logic [WW-1:0]       wr_data,
  output logic [N_SYN*WW-1:0] weights,
  output logic [N_SYN-1:0]    ltp_pulse,
  output logic [N_SYN-1:0]    ltd_pulse
);

  localparam logic [TW-1:0] WIN   = TW'(WINDOW);
  localparam logic [WW-1:0] WINIT = WW'(W_INIT);

  logic [N_SYN-1:0][TW-1:0] pre_e;
  logic [N_SYN-1:0]         pre_seen;
  logic [TW-1:0]            post_e;
  logic                     post_seen;

  logic [N_SYN-1:0][WW-1:0] w_q, w_nxt;
  logic [N_SYN-1:0]         ltp_hit, ltd_hit, wr_hit;

  stdp_timer #(.TW(TW)) u_post (
    .clk(clk), .reset(reset), .spike(post_spike), .e(post_e), .seen(post_seen)
  );

  for (genvar i = 0; i < N_SYN; i++) begin : g_syn
    stdp_timer #(.TW(TW)) u_pre (
      .clk(clk), .reset(reset), .spike(pre_spike[i]), .e(pre_e[i]), .seen(pre_seen[i])
    );

    // LTD needs post silent, so a coincident pair resolves as LTP only.
    assign ltp_hit[i] = learn_en & post_spike & pre_seen[i] & (pre_e[i] < WIN);
    assign ltd_hit[i] = learn_en & pre_spike[i] & ~post_spike & post_seen & (post_e < WIN);
    assign wr_hit[i]  = wr_en & (wr_idx == IW'(i));

    // Host write wins over learning for the addressed synapse.
    assign w_nxt[i] = wr_hit[i]  ? wr_data :
                      ltp_hit[i] ? WW'(sat_add(32'(w_q[i]),
                                       decay(LTP_MAX, 32'(pre_e[i]), DECAY_STEP), W_MAX)) :
                      ltd_hit[i] ? WW'(sat_sub(32'(w_q[i]),
                                       decay(LTD_MAX, 32'(post_e), DECAY_STEP), W_MIN)) :
                                   w_q[i];
  end

  // Weight registers and one-cycle update flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SYN; i++) w_q[i] <= WINIT;
      ltp_pulse <= '0;
      ltd_pulse <= '0;
    end else begin
      w_q       <= w_nxt;
      ltp_pulse <= ltp_hit & ~wr_hit;
      ltd_pulse <= ltd_hit & ~wr_hit;
    end
  end

  assign weights = w_q;

endmodule

// File: tb/tb_stdp_array.sv
// Randomised + directed bench for stdp_array with a cycle-level reference
// model based on absolute spike times and a decoupled scoreboard monitor.
module tb_stdp_array;

  localparam int N   = 4;
  localparam int WW  = 8;
  localparam int WIN = 16;
  localparam int DS  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    pre_spike;
  logic            post_spike, learn_en, wr_en;
  logic [1:0]      wr_idx;
  logic [WW-1:0]   wr_data;
  logic [N*WW-1:0] weights;
  logic [N-1:0]    ltp_pulse, ltd_pulse;

  always #5 clk = ~clk;

  stdp_array dut (
    .clk(clk), .reset(reset), .pre_spike(pre_spike), .post_spike(post_spike),
    .learn_en(learn_en), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .weights(weights), .ltp_pulse(ltp_pulse), .ltd_pulse(ltd_pulse)
  );

  typedef struct {
    logic [N*WW-1:0] w;
    logic [N-1:0]    ltp;
    logic [N-1:0]    ltd;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: absolute cycle of the last spike per input (-1 = none).
  int mw[N];
  int last_pre[N];
  int last_post;
  int cyc = 0;

  function automatic int elapsed(input int last, input int now);
    return (now - last > 255) ? 255 : now - last;
  endfunction

  task automatic step(input bit rst, input logic [N-1:0] pre, input bit post,
                      input bit learn, input bit we, input int idx, input int data);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    pre_spike  = pre;
    post_spike = post;
    learn_en   = learn;
    wr_en      = we;
    wr_idx     = 2'(idx);
    wr_data    = 8'(data);
    e.ltp = '0;
    e.ltd = '0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin mw[i] = 32; last_pre[i] = -1; end
      last_post = -1;
    end else begin
      for (int i = 0; i < N; i++) begin
        bit do_ltp, do_ltd;
        int ep, eq;
        ep = pre[i] ? 0 : ((last_pre[i] < 0) ? -1 : elapsed(last_pre[i], cyc));
        eq = (last_post < 0) ? -1 : elapsed(last_post, cyc);
        do_ltp = learn && post && ep >= 0 && ep < WIN;
        do_ltd = learn && pre[i] && !post && eq >= 0 && eq < WIN;
        if (we && idx == i) mw[i] = data;
        else if (do_ltp) begin
          mw[i] = mw[i] + (16 >> (ep / DS));
          if (mw[i] > 255) mw[i] = 255;
          e.ltp[i] = 1'b1;
        end else if (do_ltd) begin
          mw[i] = mw[i] - (8 >> (eq / DS));
          if (mw[i] < 0) mw[i] = 0;
          e.ltd[i] = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) if (pre[i]) last_pre[i] = cyc;
      if (post) last_post = cyc;
    end
    cyc++;
    for (int i = 0; i < N; i++) e.w[i*WW +: WW] = 8'(mw[i]);
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, 0, 1, 0, 0, 0);
  endtask

  // Monitor: one expectation per clock, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (sbq.size() > 0) begin
      exp_t x;
      x = sbq.pop_front();
      n_cmp += 3;
      if (weights !== x.w) begin
        n_bad++;
        $display("FAIL weights t=%0t got=%h want=%h", $time, weights, x.w);
      end
      if (ltp_pulse !== x.ltp) begin
        n_bad++;
        $display("FAIL ltp_pulse t=%0t got=%b want=%b", $time, ltp_pulse, x.ltp);
      end
      if (ltd_pulse !== x.ltd) begin
        n_bad++;
        $display("FAIL ltd_pulse t=%0t got=%b want=%b", $time, ltd_pulse, x.ltd);
      end
    end
  end

  initial begin
    reset = 1'b1; pre_spike = '0; post_spike = 1'b0; learn_en = 1'b1;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0;

    // 1: reset and idle
    step(1, '0, 0, 1, 0, 0, 0);
    idle(50);
    // 2: LTP at e = 3, 5, 15, 16
    step(0, 4'b0001, 0, 1, 0, 0, 0); idle(2);  step(0, '0, 1, 1, 0, 0, 0); idle(30);
    step(0, 4'b0001, 0, 1, 0, 0, 0); idle(4);  step(0, '0, 1, 1, 0, 0, 0); idle(30);
    step(0, 4'b0001, 0, 1, 0, 0, 0); idle(14); step(0, '0, 1, 1, 0, 0, 0); idle(30);
    step(0, 4'b0001, 0, 1, 0, 0, 0); idle(15); step(0, '0, 1, 1, 0, 0, 0); idle(30);
    // 3: pre with no post since reset, then LTD at e = 6
    step(1, '0, 0, 1, 0, 0, 0);
    step(0, 4'b0010, 0, 1, 0, 0, 0); idle(5);
    step(0, '0, 1, 1, 0, 0, 0); idle(5); step(0, 4'b0010, 0, 1, 0, 0, 0); idle(30);
    // 4: coincidence, upper clamp, lower clamp
    step(0, 4'b0100, 1, 1, 0, 0, 0); idle(30);
    step(0, '0, 0, 1, 1, 2, 250);
    step(0, 4'b0100, 1, 1, 0, 0, 0); idle(30);
    step(0, '0, 0, 1, 1, 3, 2);
    step(0, '0, 1, 1, 0, 0, 0); step(0, 4'b1000, 0, 1, 0, 0, 0); idle(30);
    // 5: learning disabled, host write overriding LTP
    step(0, 4'b0001, 0, 1, 0, 0, 0); idle(2); step(0, '0, 1, 0, 0, 0, 0); idle(30);
    step(0, 4'b0001, 0, 1, 0, 0, 0); idle(2); step(0, '0, 1, 1, 1, 0, 77); idle(30);
    // 6: timer saturation, then reset mid-sequence
    step(0, 4'b1111, 0, 1, 0, 0, 0); idle(300); step(0, '0, 1, 1, 0, 0, 0);
    step(0, 4'b0001, 0, 1, 0, 0, 0); step(1, '0, 0, 1, 0, 0, 0);
    step(0, '0, 1, 1, 0, 0, 0); idle(5);

    // Random traffic
    for (int k = 0; k < 2000; k++) begin
      logic [N-1:0] p;
      p = '0;
      for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 5) == 0);
      step($urandom_range(0, 399) == 0, p, $urandom_range(0, 6) == 0,
           $urandom_range(0, 9) != 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 3), $urandom_range(0, 255));
    end

    idle(2);
    @(posedge clk); #3;
    if (sbq.size() > 1) begin
      n_bad++;
      $display("FAIL drain leftover=%0d want<=1", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
